// File: rtl/keccak_chi_pkg.sv
// Shared Keccak round-datapath definitions: lane geometry, lane addressing and the
// stage FSM encoding used by the theta/rho/pi/chi/iota stages.
package keccak_chi_pkg;

  localparam int LANE_W  = 64;
  localparam int N_LANES = 25;
  localparam int ROW_W   = 5;
  localparam int ADR_W   = 5;
  localparam int IDX_W   = 3;

  typedef logic [LANE_W-1:0]             lane_t;
  typedef logic [ROW_W-1:0][LANE_W-1:0]  row_t;
  typedef logic [IDX_W-1:0]              idx_t;
  typedef logic [ADR_W-1:0]              adr_t;

  localparam idx_t LAST_IDX = idx_t'(ROW_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CALC,
    ST_WRITE,
    ST_DONE
  } chi_state_e;

  // Largest result is 4 + 5*4 = 24, so 5 bits never wrap.
  function automatic adr_t lane_index(input idx_t x, input idx_t y);
    return adr_t'(x) + adr_t'(y) * adr_t'(ROW_W);
  endfunction

endpackage

// File: rtl/keccak_chi_if.sv
// Start/done handshake plus the lane-memory port of a Keccak round stage.
interface keccak_chi_if;
  import keccak_chi_pkg::*;

  logic  start;
  lane_t in;
  logic  done;
  adr_t  mem_adr;
  lane_t mem_in;
  logic  mem_r;
  logic  mem_w;

  modport master (
    input  start, in,
    output done, mem_adr, mem_in, mem_r, mem_w
  );

  modport slave (
    output start, in,
    input  done, mem_adr, mem_in, mem_r, mem_w
  );

endinterface

// File: rtl/keccak_chi_row.sv
// Combinational chi on one 5-lane row: a[x] ^ (~a[x+1] & a[x+2]), indices mod 5.
module keccak_chi_row
  import keccak_chi_pkg::*;
(
  input  row_t row_i,
  output row_t row_o
);

  for (genvar x = 0; x < ROW_W; x++) begin : g_lane
    assign row_o[x] = row_i[x] ^ (~row_i[(x + 1) % ROW_W] & row_i[(x + 2) % ROW_W]);
  end

endmodule

// File: rtl/keccak_chi.sv
// Chi stage: sweeps the 25-lane state row by row (5 reads, wait, calc, 5 writes)
// and raises done for the iota stage once all five rows are rewritten.
module keccak_chi
  import keccak_chi_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  keccak_chi_if.master bus
);

  chi_state_e state_q, state_d;
  idx_t       x_q, x_d;
  idx_t       y_q, y_d;
  logic       done_q, done_d;
  logic       mem_r_q, mem_r_d;
  logic       mem_w_q, mem_w_d;
  adr_t       mem_adr_q, mem_adr_d;
  lane_t      mem_in_q, mem_in_d;
  row_t       b_q, b_d;
  row_t       r_q, r_d;
  row_t       row_res;
  idx_t       x_inc, x_dec, y_inc;

  keccak_chi_row u_row (
    .row_i (b_q),
    .row_o (row_res)
  );

  assign x_inc = x_q + idx_t'(1);
  assign x_dec = x_q - idx_t'(1);
  assign y_inc = y_q + idx_t'(1);

  // Outputs are computed for the state being entered so the registered strobes line up with it.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    b_d       = b_q;
    r_d       = r_q;
    done_d    = 1'b0;
    mem_r_d   = 1'b0;
    mem_w_d   = 1'b0;
    mem_adr_d = '0;
    mem_in_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !done_q) begin
          state_d   = ST_READ;
          x_d       = '0;
          y_d       = '0;
          mem_r_d   = 1'b1;
          mem_adr_d = lane_index('0, '0);
        end
      end

      ST_READ: begin
        // Read data lags the address by one cycle, so lane x-1 arrives while x is presented.
        if (x_q != '0) b_d[x_dec] = bus.in;
        if (x_q == LAST_IDX) begin
          state_d = ST_WAIT;
          x_d     = '0;
        end else begin
          x_d       = x_inc;
          mem_r_d   = 1'b1;
          mem_adr_d = lane_index(x_inc, y_q);
        end
      end

      ST_WAIT: begin
        b_d[LAST_IDX] = bus.in;
        state_d       = ST_CALC;
      end

      ST_CALC: begin
        r_d       = row_res;
        state_d   = ST_WRITE;
        x_d       = '0;
        mem_w_d   = 1'b1;
        mem_adr_d = lane_index('0, y_q);
        mem_in_d  = row_res[0];
      end

      ST_WRITE: begin
        if (x_q == LAST_IDX) begin
          if (y_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_READ;
            x_d       = '0;
            y_d       = y_inc;
            mem_r_d   = 1'b1;
            mem_adr_d = lane_index('0, y_inc);
          end
        end else begin
          x_d       = x_inc;
          mem_w_d   = 1'b1;
          mem_adr_d = lane_index(x_inc, y_q);
          mem_in_d  = r_q[x_inc];
        end
      end

      ST_DONE: begin
        done_d = bus.start;
        if (!bus.start) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the order.
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      done_q    <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      mem_adr_q <= '0;
      mem_in_q  <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      done_q    <= done_d;
      mem_r_q   <= mem_r_d;
      mem_w_q   <= mem_w_d;
      mem_adr_q <= mem_adr_d;
      mem_in_q  <= mem_in_d;
    end
  end

  // NOTE: row buffers are always filled before use, so they carry no reset.
  always_ff @(posedge clock) begin
    b_q <= b_d;
    r_q <= r_d;
  end

  assign bus.done    = done_q;
  assign bus.mem_r   = mem_r_q;
  assign bus.mem_w   = mem_w_q;
  assign bus.mem_adr = mem_adr_q;
  assign bus.mem_in  = mem_in_q;

endmodule

// File: tb/tb_keccak_chi.sv
// Self-checking bench for keccak_chi: lane memory model, strobe monitor and a
// whole-state chi reference model.
module tb_keccak_chi;
  import keccak_chi_pkg::*;

  typedef lane_t state_t [N_LANES];

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   overlap_cnt = 0;

  keccak_chi_if bus ();

  keccak_chi dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  lane_t mem [N_LANES];
  lane_t rd_data;

  always @(posedge clock) begin
    if (bus.mem_r && bus.mem_adr < 5'd25) rd_data <= mem[bus.mem_adr];
    if (bus.mem_w && bus.mem_adr < 5'd25) mem[bus.mem_adr] <= bus.mem_in;
  end
  assign bus.in = rd_data;

  // Strobe log: {is_write, address} per strobed cycle.
  logic [5:0] ev_log [$];
  always @(negedge clock) begin
    if (bus.mem_r && bus.mem_w) overlap_cnt++;
    if (bus.mem_r) ev_log.push_back({1'b0, bus.mem_adr});
    if (bus.mem_w) ev_log.push_back({1'b1, bus.mem_adr});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies chi to rows 0..rows-1 of the state, straight from the lane equation.
  function automatic state_t chi_ref(input state_t a, input int rows);
    state_t o;
    o = a;
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < 5; x++)
        o[5*y + x] = a[5*y + x] ^ (~a[5*y + (x + 1) % 5] & a[5*y + (x + 2) % 5]);
    return o;
  endfunction

  task automatic load_state(input state_t s);
    for (int i = 0; i < N_LANES; i++) mem[i] <= s[i];
    @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"},    64'(bus.done),    64'd0);
    check({tag, "_mem_r"},   64'(bus.mem_r),   64'd0);
    check({tag, "_mem_w"},   64'(bus.mem_w),   64'd0);
    check({tag, "_mem_adr"}, 64'(bus.mem_adr), 64'd0);
    check({tag, "_mem_in"},  64'(bus.mem_in),  64'd0);
  endtask

  // Raises start just before edge T0 and expects done first seen after edge T0+61.
  task automatic run_pass(input string tag);
    int lat;
    lat = -1;
    ev_log.delete();
    bus.start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_done_latency"}, 64'(lat), 64'd61);
  endtask

  task automatic check_pass(input string tag, input state_t exp);
    int bad;
    bad = 0;
    check({tag, "_strobe_count"}, 64'(ev_log.size()), 64'd50);
    if (ev_log.size() == 50) begin
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) begin
          if (ev_log[10*y + x]     !== {1'b0, 5'(5*y + x)}) bad++;
          if (ev_log[10*y + 5 + x] !== {1'b1, 5'(5*y + x)}) bad++;
        end
    end
    check({tag, "_addr_order_errs"}, 64'(bad), 64'd0);
    check({tag, "_rw_overlap"}, 64'(overlap_cnt), 64'd0);
    for (int i = 0; i < N_LANES; i++)
      check($sformatf("%s_lane%0d", tag, i), mem[i], exp[i]);
  endtask

  task automatic drop_start(input string tag);
    bus.start = 1'b0;
    @(negedge clock);
    check({tag, "_done_cleared"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    state_t s;
    state_t e;
    int     n;

    reset     = 1'b1;
    bus.start = 1'b0;
    s = '{default: '0};
    load_state(s);
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // All-zero state stays all-zero.
    run_pass("zero");
    check_pass("zero", s);

    // Holding start after done: no strobes, done held; dropping start clears done.
    n = ev_log.size();
    repeat (8) @(negedge clock);
    check("hold_no_strobes", 64'(ev_log.size()), 64'(n));
    check("hold_done_high", 64'(bus.done), 64'd1);
    drop_start("hold");

    // Re-raising start begins a fresh pass from address 0.
    run_pass("restart");
    check("restart_first_event", 64'(ev_log.size() > 0 ? ev_log[0] : 6'h3f), 64'd0);
    drop_start("restart");

    // Row 0 = {0,0,all-ones,0,0}.
    s = '{default: '0};
    s[2] = '1;
    load_state(s);
    run_pass("row0");
    check_pass("row0", chi_ref(s, 5));
    check("row0_lane0_direct", mem[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("row0_lane2_direct", mem[2], 64'hFFFF_FFFF_FFFF_FFFF);
    drop_start("row0");

    // Row 2 = {1,2,4,8,10}; lane 12 = 4 ^ (~8 & 10) = 14.
    s = '{default: '0};
    s[10] = 64'h1; s[11] = 64'h2; s[12] = 64'h4; s[13] = 64'h8; s[14] = 64'h10;
    load_state(s);
    run_pass("row2");
    check_pass("row2", chi_ref(s, 5));
    check("row2_lane10_direct", mem[10], 64'h5);
    check("row2_lane11_direct", mem[11], 64'hA);
    check("row2_lane12_direct", mem[12], 64'h14);
    check("row2_lane13_direct", mem[13], 64'h9);
    check("row2_lane14_direct", mem[14], 64'h12);
    drop_start("row2");

    // Random state, full pass.
    for (int i = 0; i < N_LANES; i++) s[i] = {$urandom, $urandom};
    load_state(s);
    run_pass("rand");
    check_pass("rand", chi_ref(s, 5));
    drop_start("rand");

    // Reset 30 edges into a pass: rows 0 and 1 are already rewritten, row 2 is not.
    for (int i = 0; i < N_LANES; i++) s[i] = {$urandom, $urandom};
    load_state(s);
    ev_log.delete();
    bus.start = 1'b1;
    repeat (31) @(negedge clock);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clock);
    check_idle_outputs("midreset");
    reset = 1'b0;
    @(negedge clock);
    e = chi_ref(chi_ref(s, 2), 5);
    run_pass("after_reset");
    check_pass("after_reset", e);
    drop_start("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
